uart_mem_bridge: RTL and testbench

Byte-level command bridge between the UART core and a 32-bit memory-mapped bus. It consumes received bytes from the UART's `data_out`/`data_out_valid`/`data_out_ready` port and parses framed read and write commands. It issues single-word memory accesses, then returns acknowledge or read-data bytes into the UART's `data_in`/`data_in_valid`/`data_in_ready` port. It sits directly downstream of the UART receiver and directly upstream of the UART transmitter.

---
 rtl/uart_mem_bridge.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
//   Parses framed byte commands from the UART receiver and turns each one into
//   a single 32-bit memory access. The reply bytes go back to the UART
//   transmitter.
//     write : 57 A1 A0 D3 D2 D1 D0  -> reply 06
//     read  : 52 A1 A0              -> reply D3 D2 D1 D0
//     other : <op>                  -> reply 15 (only the opcode byte is consumed)
//   A packet that stalls for TIMEOUT_CYCLES idle cycles between bytes is
//   silently dropped.
//
// Ports
//   clk        single clock
//   reset      synchronous, active-high
//   rx_data    byte from the UART receiver
//   rx_valid   the receiver has a byte
//   rx_ready   this block takes the byte (IDLE/ADDR/DATA only)
//   tx_data    reply byte to the UART transmitter
//   tx_valid   reply byte present
//   tx_ready   the transmitter takes the reply byte
//   mem_addr   word address; held between accesses
//   mem_wdata  write data; held between accesses
//   mem_we     one-cycle write strobe
//   mem_re     one-cycle read strobe
//   mem_rdata  read data, valid on the cycle after mem_re
//
// state      | meaning
// -----------+-----------------------------------------------------
// S_IDLE     | waiting for an opcode byte
// S_ADDR     | collecting the 2 address bytes
// S_DATA     | collecting the 4 write-data bytes
// S_MEM_WR   | mem_we asserted for this cycle
// S_MEM_RD   | mem_re asserted for this cycle
// S_MEM_WAIT | mem_rdata valid, captured into the reply
// S_RESP     | handing reply bytes to the transmitter

module uart_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 33_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    OP_WR    = 8'h57;
  localparam logic [7:0]    OP_RD    = 8'h52;
  localparam logic [7:0]    RSP_ACK  = 8'h06;
  localparam logic [7:0]    RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_MEM_WR,
    S_MEM_RD,
    S_MEM_WAIT,
    S_RESP
  } state_t;

  state_t        state_q,     state_d;
  logic          is_wr_q,     is_wr_d;
  logic [1:0]    fld_cnt_q,   fld_cnt_d;
  logic [15:0]   addr_sh_q,   addr_sh_d;
  logic [31:0]   data_sh_q,   data_sh_d;
  logic [TW-1:0] to_cnt_q,    to_cnt_d;
  logic [23:0]   resp_sh_q,   resp_sh_d;
  logic [1:0]    resp_cnt_q,  resp_cnt_d;
  logic          tx_valid_q,  tx_valid_d;
  logic [7:0]    tx_data_q,   tx_data_d;
  logic [15:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_we_q,    mem_we_d;
  logic          mem_re_q,    mem_re_d;

  logic rx_state;
  logic rx_acc;
  logic to_hit;

  // rx_ready is gated by reset so that no byte is taken on the reset edge.
  assign rx_state = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign rx_ready = rx_state && !reset;
  assign rx_acc   = rx_valid && rx_ready;
  assign to_hit   = (to_cnt_q == TO_LIMIT);

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    fld_cnt_d   = fld_cnt_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    to_cnt_d    = '0;
    resp_sh_d   = resp_sh_q;
    resp_cnt_d  = resp_cnt_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_acc) begin
          fld_cnt_d = 2'd0;
          if (rx_data == OP_WR) begin
            state_d = S_ADDR;
            is_wr_d = 1'b1;
          end else if (rx_data == OP_RD) begin
            state_d = S_ADDR;
            is_wr_d = 1'b0;
          end else begin
            state_d    = S_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_NAK;
            resp_cnt_d = 2'd0;
          end
        end
      end

      S_ADDR: begin
        if (rx_acc) begin
          addr_sh_d = {addr_sh_q[7:0], rx_data};
          fld_cnt_d = fld_cnt_q + 2'd1;
          if (fld_cnt_q == 2'd1) begin
            fld_cnt_d = 2'd0;
            if (is_wr_q) begin
              state_d = S_DATA;
            end else begin
              // Address register is loaded on entry so it is already stable
              // during the strobe cycle.
              state_d    = S_MEM_RD;
              mem_re_d   = 1'b1;
              mem_addr_d = {addr_sh_q[7:0], rx_data};
            end
          end
        end else if (to_hit) begin
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_DATA: begin
        if (rx_acc) begin
          data_sh_d = {data_sh_q[23:0], rx_data};
          fld_cnt_d = fld_cnt_q + 2'd1;
          if (fld_cnt_q == 2'd3) begin
            fld_cnt_d   = 2'd0;
            state_d     = S_MEM_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_sh_q;
            mem_wdata_d = {data_sh_q[23:0], rx_data};
          end
        end else if (to_hit) begin
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_MEM_WR: begin
        state_d    = S_RESP;
        tx_valid_d = 1'b1;
        tx_data_d  = RSP_ACK;
        resp_cnt_d = 2'd0;
      end

      S_MEM_RD: begin
        state_d = S_MEM_WAIT;
      end

      S_MEM_WAIT: begin
        state_d    = S_RESP;
        tx_valid_d = 1'b1;
        tx_data_d  = mem_rdata[31:24];
        resp_sh_d  = mem_rdata[23:0];
        resp_cnt_d = 2'd3;
      end

      S_RESP: begin
        // resp_cnt_q counts the bytes still queued behind the one on tx_data.
        if (tx_valid_q && tx_ready) begin
          if (resp_cnt_q == 2'd0) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
          end else begin
            tx_data_d  = resp_sh_q[23:16];
            resp_sh_d  = {resp_sh_q[15:0], 8'h00};
            resp_cnt_d = resp_cnt_q - 2'd1;
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      fld_cnt_q   <= 2'd0;
      addr_sh_q   <= 16'h0000;
      data_sh_q   <= 32'h0000_0000;
      to_cnt_q    <= '0;
      resp_sh_q   <= 24'h00_0000;
      resp_cnt_q  <= 2'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      fld_cnt_q   <= fld_cnt_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      to_cnt_q    <= to_cnt_d;
      resp_sh_q   <= resp_sh_d;
      resp_cnt_q  <= resp_cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Testbench for uart_mem_bridge: directed packets are driven into the rx port.
// Expected reply bytes and memory accesses are queued when a packet is issued,
// and two monitors pop and compare them when the DUT presents them.
module tb_uart_mem_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = 32'h0;

  uart_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data valid only on the cycle after mem_re.
  logic [31:0] rd_val = 32'h0;
  always @(posedge clk) mem_rdata <= mem_re ? rd_val : 32'h0BAD_0BAD;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [31:0] data;
  } mem_exp_t;

  logic [7:0] tx_q[$];
  mem_exp_t   mem_q[$];
  int         tests = 0;
  int         fails = 0;
  int         hs_count = 0;
  bit         post_chk = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reply monitor: samples just after the negedge so it sees the final
  // pre-edge values of both stimulus and DUT.
  logic [7:0] tx_e;
  always @(negedge clk) begin
    #1;
    if (post_chk) begin
      post_chk = 1'b0;
      chk("rx_ready_after_resp", rx_ready, 1);
      chk("tx_valid_drop", tx_valid, 0);
    end
    if (!reset && tx_valid && tx_ready) begin
      hs_count++;
      if (tx_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tx: got %h expected no byte", tx_data);
      end else begin
        tx_e = tx_q.pop_front();
        chk("tx_byte", tx_data, tx_e);
        if (tx_q.size() == 0) post_chk = 1'b1;
      end
    end
  end

  mem_exp_t mem_e;
  always @(negedge clk) begin
    #1;
    if (!reset && (mem_we || mem_re)) begin
      if (mem_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_mem: got we=%0b re=%0b addr %h expected none", mem_we, mem_re, mem_addr);
      end else begin
        mem_e = mem_q.pop_front();
        chk("mem_we", mem_we, mem_e.we);
        chk("mem_re", mem_re, !mem_e.we);
        chk("mem_addr", mem_addr, mem_e.addr);
        if (mem_e.we) chk("mem_wdata", mem_wdata, mem_e.data);
      end
    end
  end

  // Called on a negedge; returns on the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, output int acc);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_accept_timeout: got rx_ready=0 expected 1 within 300 cycles");
    end
    acc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int gap, output int last);
    int t;
    send_byte(8'h57, t);
    send_byte(a[15:8], t);
    send_byte(a[7:0], t);
    repeat (gap) @(negedge clk);
    send_byte(d[31:24], t);
    send_byte(d[23:16], t);
    send_byte(d[15:8], t);
    send_byte(d[7:0], t);
    last = t;
  endtask

  task automatic do_read(input logic [15:0] a, output int last);
    int t;
    send_byte(8'h52, t);
    send_byte(a[15:8], t);
    send_byte(a[7:0], t);
    last = t;
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [31:0] d);
    mem_exp_t m;
    m.we = 1'b1; m.addr = a; m.data = d;
    mem_q.push_back(m);
    tx_q.push_back(8'h06);
  endtask

  task automatic exp_read(input logic [15:0] a, input logic [31:0] d);
    mem_exp_t m;
    m.we = 1'b0; m.addr = a; m.data = 32'h0;
    mem_q.push_back(m);
    tx_q.push_back(d[31:24]);
    tx_q.push_back(d[23:16]);
    tx_q.push_back(d[15:8]);
    tx_q.push_back(d[7:0]);
  endtask

  task automatic wait_tx(input int exp_cyc, input string name);
    int n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, cyc, exp_cyc);
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_q.size() != 0 || tx_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", tx_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int base;
    int n;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rx_ready_in_reset", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    #1;
    chk("rx_ready_idle", rx_ready, 1);
    @(negedge clk);

    // Plain write.
    exp_write(16'h1234, 32'hDEAD_BEEF);
    do_write(16'h1234, 32'hDEAD_BEEF, 0, last);
    chk("wr_we_at_n1", mem_we, 1);
    chk("wr_re_at_n1", mem_re, 0);
    chk("wr_addr_at_n1", mem_addr, 16'h1234);
    chk("wr_data_at_n1", mem_wdata, 32'hDEAD_BEEF);
    wait_tx(last + 2, "ack_latency");
    chk("wr_we_one_cycle", mem_we, 0);
    chk("wr_addr_held", mem_addr, 16'h1234);
    drain();

    // Plain read.
    rd_val = 32'hCAFE_F00D;
    exp_read(16'h0010, 32'hCAFE_F00D);
    do_read(16'h0010, last);
    chk("rd_re_at_n1", mem_re, 1);
    chk("rd_we_at_n1", mem_we, 0);
    chk("rd_wdata_held", mem_wdata, 32'hDEAD_BEEF);
    wait_tx(last + 3, "read_latency");
    drain();

    // Unknown opcode, then a normal read.
    tx_q.push_back(8'h15);
    send_byte(8'h00, last);
    wait_tx(last + 1, "nak_latency");
    drain();
    rd_val = 32'h0102_0304;
    exp_read(16'h0001, 32'h0102_0304);
    do_read(16'h0001, last);
    drain();

    // Timeout: partial write abandoned, then a read still works.
    send_byte(8'h57, last);
    send_byte(8'h12, last);
    repeat (TO + 4) @(negedge clk);
    chk("to_rx_ready", rx_ready, 1);
    chk("to_tx_valid", tx_valid, 0);
    chk("to_addr_held", mem_addr, 16'h0001);
    rd_val = 32'hA5A5_5A5A;
    exp_read(16'h0002, 32'hA5A5_5A5A);
    do_read(16'h0002, last);
    drain();

    // A 15-cycle gap inside a packet is not a timeout.
    exp_write(16'h0005, 32'h1122_3344);
    do_write(16'h0005, 32'h1122_3344, TO - 1, last);
    drain();

    // Transmitter back-pressure with a byte waiting in the receiver.
    tx_ready = 1'b0;
    rd_val   = 32'hCAFE_F00D;
    exp_read(16'h0010, 32'hCAFE_F00D);
    tx_q.push_back(8'h15);
    do_read(16'h0010, last);
    wait_tx(last + 3, "bp_first_byte");
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      chk("bp_tx_valid", tx_valid, 1);
      chk("bp_tx_data", tx_data, 8'hCA);
      chk("bp_rx_ready", rx_ready, 0);
    end
    tx_ready = 1'b1;
    send_byte(8'h00, last);
    drain();

    // Reset in the middle of a read reply.
    rd_val = 32'h1122_3344;
    exp_read(16'h0020, 32'h1122_3344);
    base = hs_count;
    do_read(16'h0020, last);
    n = 0;
    while (hs_count < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_two_bytes", hs_count, base + 2);
    reset    = 1'b1;
    tx_ready = 1'b0;
    #1;
    chk("abort_rx_ready_in_reset", rx_ready, 0);
    @(negedge clk);
    reset    = 1'b0;
    tx_ready = 1'b1;
    tx_q.delete();
    #1;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_tx_data", tx_data, 8'h00);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_re", mem_re, 0);
    chk("abort_mem_addr", mem_addr, 16'h0000);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    chk("abort_rx_ready", rx_ready, 1);
    repeat (5) @(negedge clk);
    chk("abort_no_tx", tx_valid, 0);
    exp_write(16'h00AB, 32'h1357_2468);
    do_write(16'h00AB, 32'h1357_2468, 0, last);
    drain();

    chk("tx_q_empty", tx_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
